// File: rtl/pfmux_pipe.sv
// Registered N-channel valid/ready multiplexer with fixed-select or round-robin
// arbitration, packet-level grant locking and a single output register stage.
module pfmux_pipe #(
  parameter int WIDTH = 8,
  parameter int NCH   = 4,
  parameter int SELW  = 2
) (
  input  logic                 CK,
  input  logic                 CD,
  input  logic                 MODE,
  input  logic [SELW-1:0]      SEL,
  input  logic [NCH*WIDTH-1:0] DIN,
  input  logic [NCH-1:0]       DVALID,
  input  logic [NCH-1:0]       DLAST,
  output logic [NCH-1:0]       DREADY,
  output logic [WIDTH-1:0]     Z,
  output logic                 ZVALID,
  output logic                 ZLAST,
  output logic [SELW-1:0]      ZCH,
  input  logic                 ZREADY
);

  logic [WIDTH-1:0]     din_ch [NCH];
  logic [(1<<SELW)-1:0] sel_ok;
  logic                 lock;
  logic [SELW-1:0]      lock_ch;
  logic [SELW-1:0]      rr_ptr;
  logic                 rr_found;
  logic [SELW-1:0]      rr_idx;
  logic [SELW-1:0]      scan_idx;
  logic [SELW-1:0]      g;
  logic                 gx;
  logic                 ld;
  logic                 accept;

  for (genvar gi = 0; gi < NCH; gi++) begin : g_unpack
    assign din_ch[gi] = DIN[gi*WIDTH +: WIDTH];
  end

  // Select indices at or beyond NCH are legal port values but name no channel.
  for (genvar gi = 0; gi < (1 << SELW); gi++) begin : g_selok
    assign sel_ok[gi] = (gi < NCH) ? 1'b1 : 1'b0;
  end

  // Cyclic scan starting just after the last packet's winner.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    scan_idx = '0;
    for (int k = 1; k <= NCH; k++) begin
      scan_idx = SELW'((int'(rr_ptr) + k) % NCH);
      if (!rr_found && DVALID[scan_idx]) begin
        rr_found = 1'b1;
        rr_idx   = scan_idx;
      end
    end
  end

  always_comb begin
    g  = '0;
    gx = 1'b0;
    if (lock) begin
      g  = lock_ch;
      gx = 1'b1;
    end else if (!MODE) begin
      g  = SEL;
      gx = sel_ok[SEL];
    end else begin
      g  = rr_idx;
      gx = rr_found;
    end
  end

  assign ld     = !ZVALID || ZREADY;
  assign accept = ld && gx && DVALID[g];

  for (genvar gi = 0; gi < NCH; gi++) begin : g_ready
    assign DREADY[gi] = !CD && ld && gx && (g == SELW'(gi));
  end

  always_ff @(posedge CK or posedge CD) begin
    if (CD) begin
      Z       <= '0;
      ZVALID  <= 1'b0;
      ZLAST   <= 1'b0;
      ZCH     <= '0;
      lock    <= 1'b0;
      lock_ch <= '0;
      rr_ptr  <= SELW'(NCH - 1);
    end else if (ld) begin
      if (accept) begin
        Z      <= din_ch[g];
        ZLAST  <= DLAST[g];
        ZCH    <= g;
        ZVALID <= 1'b1;
        if (DLAST[g]) begin
          lock   <= 1'b0;
          rr_ptr <= g;
        end else begin
          lock    <= 1'b1;
          lock_ch <= g;
        end
      end else begin
        ZVALID <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pfmux_pipe.sv
// Directed bench for pfmux_pipe: a 4-channel instance for arbitration, locking,
// backpressure and async reset, plus a 3-channel instance for out-of-range SEL.
module tb_pfmux_pipe;

  logic       CK = 1'b0;
  logic       CD = 1'b1;
  logic       MODE = 1'b1;
  logic [1:0] SEL = 2'd0;
  logic [7:0] d [4];
  logic [31:0] DIN;
  logic [3:0] DVALID = 4'hF;
  logic [3:0] DLAST = 4'hF;
  logic [3:0] DREADY;
  logic [7:0] Z;
  logic       ZVALID, ZLAST;
  logic [1:0] ZCH;
  logic       ZREADY = 1'b1;

  logic [1:0]  sel3 = 2'd0;
  logic [7:0]  d3 [3];
  logic [23:0] din3;
  logic [2:0]  dvalid3 = 3'b000;
  logic [2:0]  dlast3 = 3'b000;
  logic [2:0]  dready3;
  logic [7:0]  z3;
  logic        zvalid3, zlast3;
  logic [1:0]  zch3;
  logic        zready3 = 1'b1;

  int vectors = 0;
  int miscompares = 0;

  assign DIN  = {d[3], d[2], d[1], d[0]};
  assign din3 = {d3[2], d3[1], d3[0]};

  always #5 CK = ~CK;

  pfmux_pipe #(.WIDTH(8), .NCH(4), .SELW(2)) dut (
    .CK(CK), .CD(CD), .MODE(MODE), .SEL(SEL), .DIN(DIN), .DVALID(DVALID),
    .DLAST(DLAST), .DREADY(DREADY), .Z(Z), .ZVALID(ZVALID), .ZLAST(ZLAST),
    .ZCH(ZCH), .ZREADY(ZREADY)
  );

  pfmux_pipe #(.WIDTH(8), .NCH(3), .SELW(2)) dut3 (
    .CK(CK), .CD(CD), .MODE(1'b0), .SEL(sel3), .DIN(din3), .DVALID(dvalid3),
    .DLAST(dlast3), .DREADY(dready3), .Z(z3), .ZVALID(zvalid3), .ZLAST(zlast3),
    .ZCH(zch3), .ZREADY(zready3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
    $display("vec %0d %s obs=%0h exp=%0h", vectors, tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) d[i] = 8'hA0 + 8'(i);
    for (int i = 0; i < 3; i++) d3[i] = 8'h00;

    // 1: reset with all channels valid, then round-robin single beats
    tick(); tick();
    chk("rst_z", 32'(Z), 32'h00);
    chk("rst_zvalid", 32'(ZVALID), 32'h0);
    chk("rst_dready", 32'(DREADY), 32'h0);
    CD = 1'b0;
    #1;
    chk("rr_first_dready", 32'(DREADY), 32'h1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rr_zch", 32'(ZCH), 32'(i % 4));
      chk("rr_z", 32'(Z), 32'(8'hA0 + 8'(i % 4)));
      chk("rr_zvalid", 32'(ZVALID), 32'h1);
    end

    // 2: fixed select, 3-beat packet on ch2, SEL moves mid-packet
    MODE = 1'b0; SEL = 2'd2; DVALID = 4'b0100; DLAST = 4'b0000; d[2] = 8'h11;
    #1 chk("fix_dready", 32'(DREADY), 32'b0100);
    tick();
    chk("fix_b1_z", 32'(Z), 32'h11);
    chk("fix_b1_zch", 32'(ZCH), 32'd2);
    chk("fix_b1_zlast", 32'(ZLAST), 32'h0);
    d[2] = 8'h22; SEL = 2'd1; DVALID = 4'b0110; d[1] = 8'h77; DLAST = 4'b0010;
    #1 chk("fix_lock_dready", 32'(DREADY), 32'b0100);
    tick();
    chk("fix_b2_z", 32'(Z), 32'h22);
    chk("fix_b2_zch", 32'(ZCH), 32'd2);
    d[2] = 8'h33; DLAST = 4'b0110;
    tick();
    chk("fix_b3_z", 32'(Z), 32'h33);
    chk("fix_b3_zch", 32'(ZCH), 32'd2);
    chk("fix_b3_zlast", 32'(ZLAST), 32'h1);
    DVALID = 4'b0010;
    #1 chk("fix_sel1_dready", 32'(DREADY), 32'b0010);
    tick();
    chk("fix_ch1_z", 32'(Z), 32'h77);
    chk("fix_ch1_zch", 32'(ZCH), 32'd1);

    // 3: round-robin, ch3 4-beat packet with a 2-cycle gap while ch0 waits
    MODE = 1'b1; DVALID = 4'b1001; DLAST = 4'b0000; d[3] = 8'hC1; d[0] = 8'hD0;
    #1 chk("rr3_dready", 32'(DREADY), 32'b1000);
    tick();
    chk("rr3_b1_z", 32'(Z), 32'hC1);
    chk("rr3_b1_zch", 32'(ZCH), 32'd3);
    DVALID = 4'b0001;
    for (int i = 0; i < 2; i++) begin
      #1 chk("bubble_dready", 32'(DREADY), 32'b1000);
      tick();
      chk("bubble_zvalid", 32'(ZVALID), 32'h0);
    end
    DVALID = 4'b1001; d[3] = 8'hC2;
    tick();
    chk("rr3_b2_z", 32'(Z), 32'hC2);
    d[3] = 8'hC3;
    tick();
    chk("rr3_b3_z", 32'(Z), 32'hC3);
    d[3] = 8'hC4; DLAST = 4'b1001;
    tick();
    chk("rr3_b4_z", 32'(Z), 32'hC4);
    chk("rr3_b4_zlast", 32'(ZLAST), 32'h1);
    DVALID = 4'b0001;
    tick();
    chk("rr3_ch0_z", 32'(Z), 32'hD0);
    chk("rr3_ch0_zch", 32'(ZCH), 32'd0);

    // 4: backpressure holds output, release accepts in the same cycle
    DVALID = 4'b0010; d[1] = 8'h5C; DLAST = 4'b0010;
    tick();
    chk("bp_load_z", 32'(Z), 32'h5C);
    ZREADY = 1'b0; d[1] = 8'h6D;
    for (int i = 0; i < 5; i++) begin
      #1 chk("bp_dready", 32'(DREADY), 32'h0);
      tick();
      chk("bp_hold", {Z, 6'd0, ZCH, 7'd0, ZLAST, 7'd0, ZVALID}, {8'h5C, 6'd0, 2'd1, 7'd0, 1'b1, 7'd0, 1'b1});
    end
    ZREADY = 1'b1;
    #1 chk("bp_release_dready", 32'(DREADY), 32'b0010);
    tick();
    chk("bp_next_z", 32'(Z), 32'h6D);
    chk("bp_next_zvalid", 32'(ZVALID), 32'h1);

    // 6: asynchronous reset while locked with a held beat
    DVALID = 4'b0100; d[2] = 8'hE1; DLAST = 4'b0000;
    tick();
    chk("ar_pre_z", 32'(Z), 32'hE1);
    ZREADY = 1'b0;
    #2 CD = 1'b1;
    #1;
    chk("ar_z", 32'(Z), 32'h0);
    chk("ar_zvalid", 32'(ZVALID), 32'h0);
    chk("ar_zch", 32'(ZCH), 32'h0);
    chk("ar_dready", 32'(DREADY), 32'h0);
    CD = 1'b0;
    DVALID = 4'b1111; DLAST = 4'b1111; ZREADY = 1'b1;
    for (int i = 0; i < 4; i++) d[i] = 8'hA0 + 8'(i);
    #1 chk("ar_after_dready", 32'(DREADY), 32'b0001);
    tick();
    chk("ar_after_zch", 32'(ZCH), 32'd0);
    chk("ar_after_z", 32'(Z), 32'hA0);

    // 5: 3-channel build, SEL=3 selects nothing; pending beat drains
    sel3 = 2'd0; dvalid3 = 3'b111; dlast3 = 3'b111;
    d3[0] = 8'h44; d3[1] = 8'h55; d3[2] = 8'h66;
    #1 chk("n3_dready0", 32'(dready3), 32'b001);
    tick();
    chk("n3_z", 32'(z3), 32'h44);
    chk("n3_zvalid", 32'(zvalid3), 32'h1);
    sel3 = 2'd3; zready3 = 1'b0;
    #1 chk("n3_sel3_dready_bp", 32'(dready3), 32'b000);
    tick();
    chk("n3_hold_zvalid", 32'(zvalid3), 32'h1);
    zready3 = 1'b1;
    #1 chk("n3_sel3_dready", 32'(dready3), 32'b000);
    tick();
    chk("n3_drain_zvalid", 32'(zvalid3), 32'h0);
    chk("n3_drain_z", 32'(z3), 32'h44);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
